mio_uart_tx: RTL
================

# mio_uart_tx

Memory-mapped UART transmitter sitting downstream of the MIO bus decoder, beside the GPIO and counter peripherals. It consumes the bus write data and a decoded write strobe, buffers bytes in a small FIFO and serialises them as 8N1 frames on a single TX pin. It returns a status word for the bus read mux and drives a level interrupt for the CPU.

## Interface
- BAUD_DIV, 868: clocks per bit; 868 gives 115200 baud at 100 MHz; legal range ≥ 2.
- FIFO_DEPTH, 8: FIFO entries; power of two, 2–16.
- clk  in  1  system clock (100 MHz board clock).
- RSTN  in  1  **One clock; reset is asynchronous and active-low.**
- uart_we  in  1  decoded write strobe from the bus decoder; one write per cycle high.
- reg_sel  in  1  0 = data register, 1 = control register.
- P_Data  in  32  bus write data.
- uart_status  out  32  status word for the read mux.
- tx  out  1  serial output, idle high.
- uart_irq  out  1  level interrupt.

## Operation
- Data write (uart_we=1, reg_sel=0): P_Data[7:0] is pushed into the FIFO if it is not full. If the FIFO is full, the byte is dropped and sticky `ovf` is set. Exception: when the FIFO is full and a pop occurs in the same cycle, the push is accepted.
- Control write (uart_we=1, reg_sel=1):
  - P_Data[0]=1 clears `ovf`.
  - P_Data[1] is loaded into `irq_en`.
  - Any other bits are ignored.
- uart_status bits:
  - [0] busy: FSM not in IDLE.
  - [1] empty.
  - [2] full.
  - [3] ovf.
  - [8:4] count, 0..FIFO_DEPTH.
  - [9] irq_en.
  - All other bits 0.
- uart_irq = irq_en & empty & ~busy. The CPU sees "transmitter drained".
- FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE/START.
  - IDLE: if the FIFO is not empty, pop into the shift register and go to START.
  - START: tx=0 for BAUD_DIV clocks.
  - DATA: 8 bits, LSB first, BAUD_DIV clocks each. A 3-bit bit index wraps 7 → exit.
  - STOP: tx=1 for BAUD_DIV clocks. If the FIFO is not empty at the end of STOP, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Baud counter: counts 0..BAUD_DIV-1. It is cleared on every state entry. The bit boundary is at count == BAUD_DIV-1.
- Reset values: tx=1, FSM=IDLE, FIFO empty (count 0), ovf=0, irq_en=0, uart_irq=0, uart_status=0x0000_0002.
- Reset asserted mid-frame:
  - tx returns high asynchronously.
  - The FIFO contents are discarded.
  - After reset release no partial frame resumes.

## Timing
- Write at edge N, FIFO empty, FSM idle:
  - Edge N+1: pop, FSM enters START.
  - tx falls after edge N+1.
- Start-to-stop-end frame length:
  - 10·BAUD_DIV clocks.
  - 11·BAUD_DIV clocks with parity.
- Back-to-back frames have zero gap.
- Status and irq are registered-state-derived combinational outputs and reflect a write on the following cycle.
- FIFO count never exceeds FIFO_DEPTH or underflows.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.

## Configuration
- UART_TX_PARITY_EN defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for BAUD_DIV clocks.
  - Frame becomes 8E1.
- Undefined: 8N1, no PARITY state, no parity logic.

## Structure
- Shared package holds:
  - FSM state enum.
  - Status bit-position constants (BUSY, EMPTY, FULL, OVF, COUNT_LSB/MSB, IRQ_EN).
  - Control bit constants (CLR_OVF, IRQ_EN).
- One sub-module, uart_tx_fifo: synchronous FIFO with push, pop, dout, count, full and empty. It uses the same clk/RSTN and is parameterised by FIFO_DEPTH.
- FSM, baud counter and register logic live in mio_uart_tx.

## Test plan
Benches run with BAUD_DIV=4.
- Reset → tx=1, uart_status=0x0000_0002, uart_irq=0. Release RSTN, idle 50 cycles → tx stays 1.
- Write 0x41 → tx samples, one per 4 clocks: 0,1,0,0,0,0,0,1,0,1. busy=1 for 40 cycles, then empty=1 and busy=0.
- Control write 0x2, then data 0x55 → uart_irq=0 during the frame and rises 1 cycle after STOP ends. Control write 0x0 → uart_irq=0.
- 9 data writes on consecutive cycles with FIFO_DEPTH=8 → one byte starts transmitting and 8 remain queued. With a different fill (9 writes while busy, FIFO already full), the 9th sets ovf=1. Control write 0x1 → ovf=0.
- Write two bytes 0xFF, 0x00 → 80 contiguous cycles with no idle gap between the stop bit and the next start bit.
- Assert RSTN low mid-DATA of 0x00 → tx=1 immediately. After release, count=0 and no further frame.
- With UART_TX_PARITY_EN, write 0x07 → parity bit=1 and frame length 44 cycles.

Source files
------------

// File: rtl/mio_uart_tx_pkg.sv
// mio_uart_tx shared types: FSM states, status and control bit positions.
// UART_TX_PARITY_EN adds the PARITY state (8E1 framing).
package mio_uart_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } tx_state_e;

   localparam int ST_BUSY      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_FULL      = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_COUNT_LSB = 4;
   localparam int ST_COUNT_MSB = 8;
   localparam int ST_IRQ_EN    = 9;
   localparam int ST_COUNT_W   = ST_COUNT_MSB - ST_COUNT_LSB + 1;

   localparam int CTRL_CLR_OVF = 0;
   localparam int CTRL_IRQ_EN  = 1;

endpackage

// File: rtl/mio_uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO for the UART transmitter.
// A push into a full FIFO is accepted only when a pop happens that cycle.
module uart_tx_fifo #(
   parameter  int FIFO_DEPTH = 8,
   parameter  int W          = 8,
   localparam int AW         = $clog2(FIFO_DEPTH),
   localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          RSTN,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [CW-1:0] cnt_q;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (cnt_q == CW'(FIFO_DEPTH));
   assign empty   = (cnt_q == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_q];
   assign count   = cnt_q;

   // Storage array; contents are don't-care while count is zero.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_q] <= din;
      end
   end

   // Pointers and occupancy; power-of-two depth lets pointers wrap freely.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) begin
            wr_q <= wr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_q <= rd_q + 1'b1;
         end
         unique case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/mio_uart_tx.sv
// mio_uart_tx: memory-mapped UART transmitter, FIFO-buffered, 8N1 frames.
// Define UART_TX_PARITY_EN for an even parity bit (8E1).
module mio_uart_tx
   import mio_uart_tx_pkg::*;
#(
   parameter int BAUD_DIV   = 868,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        RSTN,
   input  logic        uart_we,
   input  logic        reg_sel,
   input  logic [31:0] P_Data,
   output logic [31:0] uart_status,
   output logic        tx,
   output logic        uart_irq
);

   localparam int BW = $clog2(BAUD_DIV);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   tx_state_e     state_q;
   tx_state_e     state_d;
   logic [BW-1:0] baud_q;
   logic          baud_end;
   logic [7:0]    shreg_q;
   logic [2:0]    bit_q;
   logic          ovf_q;
   logic          irq_en_q;
   logic          busy;

   logic          data_we;
   logic          ctrl_we;
   logic          pop;
   logic [7:0]    dout;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;

`ifdef UART_TX_PARITY_EN
   logic          par_q;
`endif

   logic          unused_bits;

   assign unused_bits = ^P_Data[31:8];

   assign data_we  = uart_we & ~reg_sel;
   assign ctrl_we  = uart_we & reg_sel;
   assign busy     = (state_q != S_IDLE);
   assign baud_end = (baud_q == BW'(BAUD_DIV - 1));
   assign uart_irq = irq_en_q & empty & ~busy;

   uart_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .W          (8)
   ) u_fifo (
      .clk   (clk),
      .RSTN  (RSTN),
      .push  (data_we),
      .pop   (pop),
      .din   (P_Data[7:0]),
      .dout  (dout),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, FIFO pop and serial line level.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      tx      = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            tx = 1'b0;
            if (baud_end) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            tx = shreg_q[0];
            if (baud_end && (bit_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            tx = par_q;
            if (baud_end) begin
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (baud_end) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Baud counter: restarts on every state entry and every bit boundary.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         baud_q <= '0;
      end else if (!busy || baud_end || (state_d != state_q)) begin
         baud_q <= '0;
      end else begin
         baud_q <= baud_q + 1'b1;
      end
   end

   // Shift register and bit index; loaded on each pop.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         shreg_q <= '0;
         bit_q   <= '0;
      end else if (pop) begin
         shreg_q <= dout;
         bit_q   <= '0;
      end else if ((state_q == S_DATA) && baud_end) begin
         shreg_q <= {1'b0, shreg_q[7:1]};
         bit_q   <= bit_q + 1'b1;
      end
   end

`ifdef UART_TX_PARITY_EN
   // Even parity of the popped byte, held for the PARITY bit.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         par_q <= 1'b0;
      end else if (pop) begin
         par_q <= ^dout;
      end
   end
`endif

   // Sticky overflow and interrupt enable control bits.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         ovf_q    <= 1'b0;
         irq_en_q <= 1'b0;
      end else begin
         if (ctrl_we) begin
            irq_en_q <= P_Data[CTRL_IRQ_EN];
         end
         if (ctrl_we && P_Data[CTRL_CLR_OVF]) begin
            ovf_q <= 1'b0;
         end else if (data_we && full && !pop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Status word for the bus read mux.
   always_comb begin
      uart_status = '0;
      uart_status[ST_BUSY]   = busy;
      uart_status[ST_EMPTY]  = empty;
      uart_status[ST_FULL]   = full;
      uart_status[ST_OVF]    = ovf_q;
      uart_status[ST_IRQ_EN] = irq_en_q;
      uart_status[ST_COUNT_MSB:ST_COUNT_LSB] = ST_COUNT_W'(count);
   end

endmodule
